dct_transpose: RTL and testbench
================================

// Module: dct_transpose
// PURPOSE
//  Double-buffered 8x8 transpose memory for the 2-D DCT. Sits between the row
//  pass (dct_1d) and the column pass (second dct_1d).
//  - Writes row-pass coefficients in row-major order.
//  - Emits each completed block column-major as a gap-free 64-cycle burst.
//  - Filling one bank overlaps draining the other, so blocks can stream
//    back-to-back.
// PARAMETERS
//  W   12  sample width (two's complement), passed through unmodified
//  N   8   block dimension; power of two, >=2; block size B = N*N
// PORTS
//  clk       in   1  clock
//  rst       in   1  synchronous, active-high reset
//  in_valid  in   1  in_data is a sample this cycle (may be gapped)
//  in_data   in   W  row-major sample; k-th accepted sample is (row=k/N, col=k%N)
//  out_valid out  1  out_data valid this cycle
//  out_data  out  W  column-major sample; j-th of burst is (row=j%N, col=j/N)
//  out_first out  1  with out_valid, marks element j=0 of a block
//  out_last  out  1  with out_valid, marks element j=B-1 of a block
// BEHAVIOUR
//  - Storage: two banks of B words each. Write counter wr_idx (log2 B bits) and
//    bank select wr_bank.
//  - On each cycle with in_valid=1:
//    - write mem[wr_bank][wr_idx]; wr_idx++.
//    - when wr_idx wraps B-1 -> 0: toggle wr_bank and set pending[old bank].
//  - Reader FSM, states IDLE and READ:
//    - IDLE -> READ when any pending bit is set. Capture rd_bank, rd_idx=0, and
//      clear that pending bit in the same cycle.
//    - READ: each cycle, read address = rd_bank*B + (rd_idx%N)*N + rd_idx/N;
//      rd_idx++.
//    - At rd_idx=B-1: if the other bank is pending, swap rd_bank, restart at 0
//      and clear its pending bit, with no gap. Otherwise return to IDLE.
//  - Memory read is registered, so out_valid/out_data/out_first/out_last lag
//    the read address by 1 cycle.
//  - Latency: if sample B-1 is presented (in_valid=1) in cycle c, element j=0
//    appears in cycle c+2.
//  - Bursts always occupy B consecutive cycles. The output rate is independent
//    of input gaps.
//  - No overwrite hazard:
//    - A bank is rewritten at the earliest B+1 cycles after its fill completes.
//    - By then its read burst has ended.
//    - No backpressure or overflow port is needed.
//  - Simultaneous events:
//    - a fill completing while a read is in progress sets pending only; the
//      burst is not disturbed.
//    - a fill completing in the same cycle the reader finishes triggers a
//      seamless bank swap.
//  - Reset (also mid-block or mid-burst), values after the reset edge:
//    - wr_idx=0, wr_bank=0, pending=0, FSM=IDLE.
//    - out_valid=0, out_first=0, out_last=0, out_data=0.
//    - Bank contents are don't-care. Partial input and any in-flight burst are
//      discarded.
//    - in_valid is ignored during rst.
//  - Width rule: data is stored and emitted bit-exact; no sign handling or
//    arithmetic.
//  - out_data holds 0 whenever out_valid=0.
// TESTING
//  1. Ramp: in_data=0..63, in_valid continuous
//     -> out_data 0,8,16,..,56,1,9,..,63 starting at c+2;
//        out_first on 0, out_last on 63.
//  2. Back-to-back: two ramp blocks (0..63, 100..163) with no idle cycles
//     -> 128 contiguous out_valid cycles; second burst begins 0+100, 8+100, ...
//  3. Gapped input: in_valid every 3rd cycle, ramp block
//     -> output still 64 consecutive cycles, first element at c+2 after
//        sample 63.
//  4. Reset mid-fill: 30 samples, rst for 1 cycle, then full ramp
//     -> exactly one burst, containing only the post-reset ramp.
//  5. Reset mid-burst: assert rst at burst element 20
//     -> out_valid low from the next cycle; no further output until a new
//        block completes.
//  6. Sign/width: block of alternating -2048 (0x800) and 2047 (0x7FF), W=12
//     -> transposed values bit-exact.

Source files
------------

// File: rtl/dct_transpose.sv
// dct_transpose: double-buffered NxN transpose memory, row-major in, column-major gap-free bursts out
module dct_transpose #(
  parameter int W = 12,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_first,
  output logic         out_last
);
  localparam int B  = N * N;
  localparam int LN = $clog2(N);
  localparam int AW = 2 * LN;
  typedef enum logic {IDLE, READ} state_t;
  state_t r_state, w_state_nx;
  logic [W-1:0] r_mem [2*B];
  logic [AW-1:0] r_wr_idx, r_rd_idx, w_idx, w_idx_nx;
  logic r_wr_bank, r_rd_bank, w_bank, w_bank_nx;
  logic [1:0] r_pend, w_set, w_clr;
  logic w_fill, w_start, w_act, w_end, w_swap;
  logic [AW:0] w_addr;
  // The IDLE->READ cycle already issues element 0, giving c+2 latency and seamless restarts
  always_comb begin
    w_fill     = in_valid && r_wr_idx == AW'(B - 1);
    w_start    = r_state == IDLE && |r_pend;
    w_act      = r_state == READ || w_start;
    w_bank     = r_state == READ ? r_rd_bank : !r_pend[0];
    w_idx      = r_state == READ ? r_rd_idx : '0;
    w_end      = w_act && w_idx == AW'(B - 1);
    w_swap     = w_end && r_pend[!w_bank];
    w_addr     = {w_bank, w_idx[LN-1:0], w_idx[AW-1:LN]};
    w_bank_nx  = w_swap ? !w_bank : w_bank;
    w_idx_nx   = w_swap ? '0 : w_idx + AW'(1);
    w_state_nx = (w_act && !(w_end && !w_swap)) ? READ : IDLE;
    w_set      = w_fill ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    w_clr      = w_swap ? (w_bank ? 2'b01 : 2'b10) : w_start ? (w_bank ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk)
    if (!rst && in_valid) r_mem[{r_wr_bank, r_wr_idx}] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wr_idx  <= '0;
      r_wr_bank <= 1'b0;
      r_pend    <= 2'b00;
      r_rd_idx  <= '0;
      r_rd_bank <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rd_idx  <= w_idx_nx;
      r_rd_bank <= w_bank_nx;
      r_pend    <= (r_pend & ~w_clr) | w_set;
      if (in_valid) r_wr_idx <= r_wr_idx + AW'(1);
      if (w_fill) r_wr_bank <= !r_wr_bank;
      out_valid <= w_act;
      out_data  <= w_act ? r_mem[w_addr] : '0;
      out_first <= w_act && w_idx == '0;
      out_last  <= w_end;
    end
  end
endmodule

// File: tb/tb_dct_transpose.sv
// tb_dct_transpose: scheduled-burst reference model with per-cycle compare plus literal spot checks
module tb_dct_transpose;
  localparam int W = 12, N = 8, B = N * N;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic out_valid, out_first, out_last;
  logic [W-1:0] out_data;
  typedef struct {int t; logic [W-1:0] d; logic f; logic l;} exp_t;
  exp_t exp_q[$];
  logic [W-1:0] blk[B];
  logic [W-1:0] cap[$];
  int k = 0, next_free = 0, cyc = 0, s = 0, errors = 0, checks = 0, first_cyc = -1, last_in = 0;
  bit started = 0;
  logic ev, ef, el;
  logic [W-1:0] ed;

  dct_transpose #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // each completed block becomes a column-major burst scheduled at max(c+2, end of previous burst)
  always @(posedge clk) begin
    if (rst) begin
      k = 0; exp_q.delete(); next_free = 0; started = 1;
    end else if (in_valid) begin
      blk[k] = in_data; k++;
      if (k == B) begin
        s = (cyc + 2 > next_free) ? cyc + 2 : next_free;
        for (int j = 0; j < B; j++)
          exp_q.push_back('{s + j, blk[(j % N) * N + j / N], logic'(j == 0), logic'(j == B - 1)});
        next_free = s + B; k = 0;
      end
    end
    cyc++;
  end

  always @(negedge clk) if (started) begin
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      ev = 1; ed = exp_q[0].d; ef = exp_q[0].f; el = exp_q[0].l;
      void'(exp_q.pop_front());
    end else begin
      ev = 0; ed = '0; ef = 0; el = 0;
    end
    checks++;
    if ({out_valid, out_first, out_last, out_data} !== {ev, ef, el, ed}) begin
      errors++;
      $display("FAIL out cyc=%0d got v=%b f=%b l=%b d=%h want v=%b f=%b l=%b d=%h",
               cyc, out_valid, out_first, out_last, out_data, ev, ef, el, ed);
    end
    if (out_valid) begin
      cap.push_back(out_data);
      if (out_first) first_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int d);
    last_in = cyc; in_valid = 1; in_data = W'(d);
    @(posedge clk); #1;
    in_valid = 0; in_data = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
    end
    idle(3);
  endtask

  task automatic start_cap();
    cap.delete(); first_cyc = -1;
  endtask

  initial begin
    idle(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    rst = 0;
    idle(2);
    start_cap();
    for (int i = 0; i < B; i++) push(i);
    drain();
    chk("t1_latency", first_cyc - last_in, 2);
    chk("t1_len", cap.size(), 64);
    if (cap.size() == 64) begin
      chk("t1_e1", int'(cap[1]), 8);
      chk("t1_e8", int'(cap[8]), 1);
      chk("t1_e9", int'(cap[9]), 9);
      chk("t1_e63", int'(cap[63]), 63);
    end
    start_cap();
    for (int i = 0; i < B; i++) push(i);
    for (int i = 0; i < B; i++) push(100 + i);
    drain();
    chk("t2_len", cap.size(), 128);
    if (cap.size() == 128) begin
      chk("t2_e63", int'(cap[63]), 63);
      chk("t2_e64", int'(cap[64]), 100);
      chk("t2_e65", int'(cap[65]), 108);
      chk("t2_e127", int'(cap[127]), 163);
    end
    start_cap();
    for (int i = 0; i < B; i++) begin push(200 + i); idle(2); end
    drain();
    chk("t3_len", cap.size(), 64);
    if (cap.size() == 64) chk("t3_e1", int'(cap[1]), 208);
    start_cap();
    for (int i = 0; i < 30; i++) push(500 + i);
    in_valid = 1; in_data = W'(999); rst = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; in_data = '0;
    for (int i = 0; i < B; i++) push(i);
    drain();
    chk("t4_len", cap.size(), 64);
    if (cap.size() == 64) begin
      chk("t4_e0", int'(cap[0]), 0);
      chk("t4_e1", int'(cap[1]), 8);
    end
    start_cap();
    for (int i = 0; i < B; i++) push(300 + i);
    idle(21);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    idle(80);
    chk("t5_len", cap.size(), 21);
    start_cap();
    for (int i = 0; i < B; i++) push((i % 2) ? 12'h7FF : 12'h800);
    drain();
    chk("t6_len", cap.size(), 64);
    if (cap.size() == 64) begin
      chk("t6_e0", int'(cap[0]), 12'h800);
      chk("t6_e1", int'(cap[1]), 12'h800);
      chk("t6_e8", int'(cap[8]), 12'h7FF);
      chk("t6_e9", int'(cap[9]), 12'h7FF);
    end
    for (int b = 0; b < 8; b++) begin
      int mode = $urandom_range(0, 4);
      for (int i = 0; i < B; i++) begin
        push(int'($urandom_range(0, 4095)));
        if ($urandom_range(0, 3) < mode) idle($urandom_range(1, 3));
      end
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
